// File: rtl/nx_fifo_out_pipe.sv
// nx_fifo_out_pipe: registered read-side output stage for a show-ahead nx_fifo.
// A two-entry skid buffer (head + skid) pops the FIFO and presents a
// valid/ready stream. The pop request never depends on out_ready.
//
// Handshake: a beat transfers on a rising edge where out_valid=1 and
// out_ready=1. While out_valid=1 and out_ready=0, out_data holds steady.
// Upstream, fifo_ren=1 pops the FIFO head on the same edge, and fifo_ren
// is only raised while fifo_empty=0.
module nx_fifo_out_pipe #(
  parameter int WIDTH      = 611,
  parameter bit DATA_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_ren,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  // Occupancy doubles as the controller state and is exposed as occupancy.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e             occ_q;
  occ_e             occ_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             flush;
  logic             push;
  logic             pop;

  // rst and clear both flush the buffer and suppress any pop or handshake.
  assign flush    = rst | clear;
  // Depends only on local occupancy and fifo_empty, so there is no
  // combinational path from out_ready to fifo_ren.
  assign fifo_ren = !flush && !fifo_empty && (occ_q != OCC_FULL);
  assign push     = fifo_ren;
  assign pop      = (occ_q != OCC_EMPTY) && out_ready;

  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = (DATA_RESET && (occ_q == OCC_EMPTY)) ? '0 : head_q;
  assign occupancy = occ_q;

  // Next-state and datapath selection; flush takes priority over push/pop.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
      if (DATA_RESET) begin
        head_d = '0;
        skid_d = '0;
      end
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            head_d = fifo_rdata;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({push, pop})
            2'b10: begin
              skid_d = fifo_rdata;
              occ_d  = OCC_FULL;
            end
            2'b01: begin
              occ_d = OCC_EMPTY;
              if (DATA_RESET) head_d = '0;
            end
            2'b11: begin
              head_d = fifo_rdata;
            end
            default: ;
          endcase
        end
        OCC_FULL: begin
          // push is impossible here, so the skid entry simply moves up.
          if (pop) begin
            head_d = skid_q;
            occ_d  = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // State register with synchronous reset; data follows the next-state logic.
  always_ff @(posedge clk) begin
    if (rst) occ_q <= OCC_EMPTY;
    else     occ_q <= occ_d;
    head_q <= head_d;
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_nx_fifo_out_pipe.sv
// Testbench for nx_fifo_out_pipe: drives a DATA_RESET=1 and a DATA_RESET=0
// instance from one upstream FIFO model and scoreboards both outputs.
module tb_nx_fifo_out_pipe;

  localparam int W = 16;

  // ---------------- clock / reset / signals ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         fifo_empty;
  logic [W-1:0] fifo_rdata;
  logic         out_ready;
  logic         ren_a, valid_a, ren_b, valid_b;
  logic [W-1:0] data_a, data_b;
  logic [1:0]   occ_a, occ_b;

  always #5 clk = ~clk;

  nx_fifo_out_pipe #(.WIDTH(W), .DATA_RESET(1'b1)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_ren(ren_a), .out_valid(valid_a),
    .out_data(data_a), .out_ready(out_ready), .occupancy(occ_a)
  );

  nx_fifo_out_pipe #(.WIDTH(W), .DATA_RESET(1'b0)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_ren(ren_b), .out_valid(valid_b),
    .out_data(data_b), .out_ready(out_ready), .occupancy(occ_b)
  );

  // ---------------- upstream FIFO model and scoreboard ----------------
  logic [W-1:0] fifo_m[$];
  logic [W-1:0] exp_q[$];
  int           errors  = 0;
  int           checks  = 0;
  int           acc_cnt = 0;
  bit           mon_en  = 1'b0;
  int           exp_occ;
  logic         exp_ren;

  task automatic drive_fifo();
    if (fifo_m.size() == 0) begin
      fifo_empty = 1'b1;
      fifo_rdata = '0;
    end else begin
      fifo_empty = 1'b0;
      fifo_rdata = fifo_m[0];
    end
  endtask

  task automatic fifo_write(input logic [W-1:0] w);
    fifo_m.push_back(w);
    drive_fifo();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // The FIFO head presented to the DUT follows model pops after each edge.
  initial forever begin
    @(posedge clk);
    #1;
    drive_fifo();
  end

  // Every cycle: check pop request, occupancy, valid and data against the
  // model, then apply this cycle's handshakes to the model.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_occ = exp_q.size();
      exp_ren = !rst && !clear && !fifo_empty && (exp_occ < 2);
      checks++;
      if (ren_a !== exp_ren) begin
        errors++; $display("FAIL ren_a t=%0t got %b want %b", $time, ren_a, exp_ren);
      end
      checks++;
      if (ren_b !== exp_ren) begin
        errors++; $display("FAIL ren_b t=%0t got %b want %b", $time, ren_b, exp_ren);
      end
      checks++;
      if (occ_a !== exp_occ[1:0]) begin
        errors++; $display("FAIL occ_a t=%0t got %0d want %0d", $time, occ_a, exp_occ);
      end
      checks++;
      if (occ_b !== exp_occ[1:0]) begin
        errors++; $display("FAIL occ_b t=%0t got %0d want %0d", $time, occ_b, exp_occ);
      end
      checks++;
      if (valid_a !== (exp_occ != 0)) begin
        errors++; $display("FAIL valid_a t=%0t got %b want %b", $time, valid_a, exp_occ != 0);
      end
      checks++;
      if (valid_b !== (exp_occ != 0)) begin
        errors++; $display("FAIL valid_b t=%0t got %b want %b", $time, valid_b, exp_occ != 0);
      end
      if (exp_occ != 0) begin
        checks++;
        if (data_a !== exp_q[0]) begin
          errors++; $display("FAIL data_a t=%0t got %0h want %0h", $time, data_a, exp_q[0]);
        end
        checks++;
        if (data_b !== exp_q[0]) begin
          errors++; $display("FAIL data_b t=%0t got %0h want %0h", $time, data_b, exp_q[0]);
        end
      end else begin
        checks++;
        if (data_a !== '0) begin
          errors++; $display("FAIL data_a_masked t=%0t got %0h want 0", $time, data_a);
        end
      end
      if (rst || clear) begin
        exp_q.delete();
      end else begin
        if ((exp_occ != 0) && out_ready) begin
          void'(exp_q.pop_front());
          acc_cnt++;
        end
        if (exp_ren) exp_q.push_back(fifo_m.pop_front());
      end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; out_ready = 1'b0;
    drive_fifo();
    next_cycle();
    mon_en = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_a); end
    checks++;
    if (occ_a !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occ_a); end
    checks++;
    if (data_a !== '0) begin errors++; $display("FAIL reset_data got %0h want 0", data_a); end
    checks++;
    if (ren_a !== 1'b0) begin errors++; $display("FAIL reset_ren got %b want 0", ren_a); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [W-1:0] words[3];
    int ren_cnt;
    words[0] = 16'h000A; words[1] = 16'h000B; words[2] = 16'h000C;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) fifo_write(words[i]);
    ren_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ren_a) ren_cnt++;
      if (valid_a) begin
        checks++;
        if (data_a !== 16'h000A) begin
          errors++; $display("FAIL fill_stall_data got %0h want a", data_a);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (ren_cnt != 2) begin errors++; $display("FAIL fill_ren_pulses got %0d want 2", ren_cnt); end
    checks++;
    if (occ_a !== 2'd2) begin errors++; $display("FAIL fill_occ got %0d want 2", occ_a); end
    checks++;
    if (ren_a !== 1'b0) begin errors++; $display("FAIL fill_ren_full got %b want 0", ren_a); end
    next_cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b1 || data_a !== words[i]) begin
        errors++;
        $display("FAIL fill_drain beat %0d got v=%b d=%0h want v=1 d=%0h", i, valid_a, data_a, words[i]);
      end
      next_cycle();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    int first_ren, first_valid, beats;
    first_ren = -1; first_valid = -1; beats = 0;
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) fifo_write(16'h0100 + 16'(j));
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (ren_a && first_ren < 0) first_ren = cyc;
      if (valid_a) begin
        if (first_valid < 0) first_valid = cyc;
        checks++;
        if (cyc != first_valid + beats) begin
          errors++; $display("FAIL stream_gap cycle %0d got beat %0d want cycle %0d", cyc, beats, first_valid + beats);
        end
        checks++;
        if (data_a !== 16'h0100 + 16'(beats)) begin
          errors++; $display("FAIL stream_data got %0h want %0h", data_a, 16'h0100 + 16'(beats));
        end
        checks++;
        if (occ_a !== 2'd1) begin
          errors++; $display("FAIL stream_occ got %0d want 1", occ_a);
        end
        beats++;
      end
      next_cycle();
    end
    checks++;
    if (first_ren < 0 || first_valid != first_ren + 1) begin
      errors++; $display("FAIL stream_latency got valid@%0d want ren@%0d+1", first_valid, first_ren);
    end
    checks++;
    if (beats != 8) begin errors++; $display("FAIL stream_beats got %0d want 8", beats); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc_start, cycles;
    acc_start = acc_cnt;
    cycles = 0;
    while ((acc_cnt - acc_start) < 10000 && cycles < 60000) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 && fifo_m.size() < 8)
        fifo_write(W'($urandom_range(0, 65535)));
      next_cycle();
      cycles++;
    end
    checks++;
    if ((acc_cnt - acc_start) < 10000) begin
      errors++; $display("FAIL bp_budget got %0d beats want 10000", acc_cnt - acc_start);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      next_cycle();
      if (fifo_m.size() == 0 && exp_q.size() == 0) break;
    end
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b0 || fifo_m.size() != 0) begin
      errors++; $display("FAIL bp_drain got v=%b fifo=%0d want v=0 fifo=0", valid_a, fifo_m.size());
    end
    next_cycle();
    out_ready = 1'b0;
  endtask

  task automatic wait_full(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (occ_a === 2'd2) begin seen = 1'b1; break; end
      next_cycle();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_fill got occ=%0d want 2", name, occ_a); end
  endtask

  task automatic test_clear();
    int acc0;
    bit seen;
    out_ready = 1'b0;
    fifo_write(16'h0001);
    fifo_write(16'h0002);
    wait_full("clear");
    next_cycle();
    clear = 1'b1; out_ready = 1'b1;
    acc0 = acc_cnt;
    @(negedge clk);
    next_cycle();
    clear = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b0 || occ_a !== 2'd0 || data_a !== '0) begin
      errors++; $display("FAIL clear_state got v=%b occ=%0d d=%0h want 0 0 0", valid_a, occ_a, data_a);
    end
    checks++;
    if (acc_cnt != acc0) begin errors++; $display("FAIL clear_accept got %0d want %0d", acc_cnt, acc0); end
    next_cycle();
    fifo_write(16'h0003);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid_a) begin
        seen = 1'b1;
        checks++;
        if (data_a !== 16'h0003) begin errors++; $display("FAIL clear_next got %0h want 3", data_a); end
        break;
      end
      next_cycle();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL clear_next_timeout got no beat want 3"); end
    next_cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_rst_stall();
    out_ready = 1'b0;
    fifo_write(16'h0004);
    fifo_write(16'h0005);
    fifo_write(16'h0006);
    wait_full("rst");
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ren_a !== 1'b0 || fifo_empty !== 1'b0) begin
        errors++; $display("FAIL rst_ren got ren=%b empty=%b want ren=0 empty=0", ren_a, fifo_empty);
      end
      if (i >= 1) begin
        checks++;
        if (valid_a !== 1'b0 || occ_a !== 2'd0 || data_a !== '0) begin
          errors++; $display("FAIL rst_state got v=%b occ=%0d d=%0h want 0 0 0", valid_a, occ_a, data_a);
        end
      end
      next_cycle();
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if (fifo_m.size() == 0 && exp_q.size() == 0) break;
    end
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b0 || fifo_m.size() != 0) begin
      errors++; $display("FAIL rst_drain got v=%b fifo=%0d want v=0 fifo=0", valid_a, fifo_m.size());
    end
    next_cycle();
    out_ready = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill();
    test_streaming();
    test_backpressure();
    test_clear();
    test_rst_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
